// File: rtl/midi_pkg.sv
// midi_pkg: shared constants, parser state type and helpers for the MIDI-to-register bridge.
//   NOTE_OFF..CHPRESS : channel voice status nibbles the bridge understands
//   CC_ALL_NOTES_OFF  : controller number that releases a channel's note
//   parser_state_e    : running-status parser states
//   data_bytes_for()  : data bytes carried by a channel voice message
package midi_pkg;

  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] CTRL     = 4'hB;
  localparam logic [3:0] PROG     = 4'hC;
  localparam logic [3:0] CHPRESS  = 4'hD;

  localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;

  typedef enum logic [1:0] {
    StIdle,
    StWaitD1,
    StWaitD2
  } parser_state_e;

  // Program change and channel pressure carry one data byte; every other
  // channel voice message carries two.
  function automatic logic [1:0] data_bytes_for(input logic [3:0] status);
    if (status == PROG || status == CHPRESS) begin
      return 2'd1;
    end
    return 2'd2;
  endfunction

endpackage

// File: rtl/midi_parser.sv
// midi_parser: running-status MIDI channel voice message framer.
//   clk, rst        : clock, synchronous active-high reset
//   rx_data_i       : received byte, qualified by rx_valid_i
//   msg_valid_o     : one-cycle strobe, combinational with the completing data byte
//   status_o        : status nibble of the completed message
//   channel_o       : MIDI channel of the completed message
//   d1_o, d2_o      : data bytes (d2_o is 0 for one-byte messages)
module midi_parser
  import midi_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  output logic       msg_valid_o,
  output logic [3:0] status_o,
  output logic [3:0] channel_o,
  output logic [6:0] d1_o,
  output logic [6:0] d2_o
);

  parser_state_e state_q, state_d;
  logic [3:0]    status_q, status_d;
  logic [3:0]    chan_q, chan_d;
  logic [6:0]    d1_q, d1_d;

  logic is_data;
  logic is_status;
  logic is_sys_common;
  logic one_byte_msg;

  // Real-time bytes (F8-FF) match none of these and leave everything untouched.
  assign is_data       = rx_valid_i && !rx_data_i[7];
  assign is_status     = rx_valid_i && rx_data_i[7] && (rx_data_i[7:4] != 4'hF);
  assign is_sys_common = rx_valid_i && (rx_data_i[7:3] == 5'b11110);
  assign one_byte_msg  = (data_bytes_for(status_q) == 2'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      status_q <= 4'h0;
      chan_q   <= 4'h0;
      d1_q     <= 7'h00;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      chan_q   <= chan_d;
      d1_q     <= d1_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    chan_d   = chan_q;
    d1_d     = d1_q;
    if (is_status) begin
      // A new status abandons any partial message.
      state_d  = StWaitD1;
      status_d = rx_data_i[7:4];
      chan_d   = rx_data_i[3:0];
    end else if (is_sys_common) begin
      state_d = StIdle;
    end else if (is_data) begin
      case (state_q)
        StIdle: ;
        StWaitD1: begin
          d1_d    = rx_data_i[6:0];
          state_d = one_byte_msg ? StWaitD1 : StWaitD2;
        end
        StWaitD2: state_d = StWaitD1;
        default:  state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    msg_valid_o = 1'b0;
    status_o    = status_q;
    channel_o   = chan_q;
    d1_o        = d1_q;
    d2_o        = 7'h00;
    if (is_data) begin
      case (state_q)
        StWaitD1: begin
          if (one_byte_msg) begin
            msg_valid_o = 1'b1;
            d1_o        = rx_data_i[6:0];
          end
        end
        StWaitD2: begin
          msg_valid_o = 1'b1;
          d2_o        = rx_data_i[6:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/midi_reg_master.sv
// midi_reg_master: turns a MIDI byte stream into single-cycle register writes of
// {gate, note} per floppy channel, keeping one monophonic note record per channel.
//   clk, rst     : clock, synchronous active-high reset
//   rx_data      : received MIDI byte, qualified by rx_valid
//   reg_addr     : {2'b0, channel}, registered, holds between requests
//   write        : write qualifier, pulses with new_req
//   new_req      : one-cycle request strobe, cycle after the completing byte
//   write_value  : {gate, note[6:0]}, registered, holds between requests
module midi_reg_master
  import midi_pkg::*;
#(
  parameter int unsigned NUM_CH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [5:0] reg_addr,
  output logic       write,
  output logic       new_req,
  output logic [7:0] write_value
);

  localparam int unsigned IdxW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic       msg_valid;
  logic [3:0] msg_status;
  logic [3:0] msg_channel;
  logic [6:0] msg_d1;
  logic [6:0] msg_d2;

  midi_parser u_parser (
    .clk         (clk),
    .rst         (rst),
    .rx_data_i   (rx_data),
    .rx_valid_i  (rx_valid),
    .msg_valid_o (msg_valid),
    .status_o    (msg_status),
    .channel_o   (msg_channel),
    .d1_o        (msg_d1),
    .d2_o        (msg_d2)
  );

  logic [NUM_CH-1:0]      playing_q, playing_d;
  logic [NUM_CH-1:0][6:0] cur_note_q, cur_note_d;
  logic                   req_q, req_d;
  logic [5:0]             addr_q, addr_d;
  logic [7:0]             value_q, value_d;

  logic            ch_ok;
  logic [IdxW-1:0] ch_idx;
  logic            note_release;

  // Channels at or above NUM_CH have no floppy behind them; drop their messages.
  assign ch_ok  = 32'(msg_channel) < NUM_CH;
  assign ch_idx = msg_channel[IdxW-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      playing_q  <= '0;
      cur_note_q <= '0;
      req_q      <= 1'b0;
      addr_q     <= 6'h00;
      value_q    <= 8'h00;
    end else begin
      playing_q  <= playing_d;
      cur_note_q <= cur_note_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      value_q    <= value_d;
    end
  end

  always_comb begin
    playing_d    = playing_q;
    cur_note_d   = cur_note_q;
    req_d        = 1'b0;
    addr_d       = addr_q;
    value_d      = value_q;
    note_release = 1'b0;
    if (msg_valid && ch_ok) begin
      case (msg_status)
        NOTE_ON: begin
          if (msg_d2 != 7'h00) begin
            // Monophonic: a new note simply overwrites whatever was sounding.
            playing_d[ch_idx]  = 1'b1;
            cur_note_d[ch_idx] = msg_d1;
            req_d              = 1'b1;
            value_d            = {1'b1, msg_d1};
          end else begin
            note_release = playing_q[ch_idx] && (msg_d1 == cur_note_q[ch_idx]);
          end
        end
        NOTE_OFF: note_release = playing_q[ch_idx] && (msg_d1 == cur_note_q[ch_idx]);
        CTRL:     note_release = playing_q[ch_idx] && (msg_d1 == CC_ALL_NOTES_OFF);
        default:  ;
      endcase
      if (note_release) begin
        playing_d[ch_idx] = 1'b0;
        req_d             = 1'b1;
        value_d           = {1'b0, cur_note_q[ch_idx]};
      end
      if (req_d) begin
        addr_d = {2'b00, msg_channel};
      end
    end
  end

  assign new_req     = req_q;
  assign write       = req_q;
  assign reg_addr    = addr_q;
  assign write_value = value_q;

endmodule

// File: doc/midi_reg_master.md
# midi_reg_master

Register-bus initiator that converts a MIDI byte stream from the UART receiver into single-cycle register writes toward the floppy register controller. Parses channel voice messages with running status, keeps a monophonic note/gate record per floppy channel, and issues writes of `{enable, note[6:0]}` to register address = MIDI channel. It is the requesting end of the `reg_addr`/`write`/`new_req`/`write_value` interface.

## Interface

- `NUM_CH`, default 8: number of floppy channels; MIDI channels 0..NUM_CH-1 map to register addresses 0..NUM_CH-1. Legal range is 1..16; other channels are ignored.
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `rx_data`  in  8  received MIDI byte
- `rx_valid`  in  1  one-cycle strobe; `rx_data` is valid
- `reg_addr`  out  6  register address, `{2'b0, channel}`
- `write`  out  1  write qualifier; high with every `new_req`
- `new_req`  out  1  one-cycle request strobe
- `write_value`  out  8  `{gate, note[6:0]}`

## Operation

- Parser states: IDLE (no running status), WAIT_D1, WAIT_D2.
- Status byte 0x80–0xEF: latches the status nibble and channel as running status, abandons any partial message, and moves to WAIT_D1.
- Bytes 0xF8–0xFF (real-time): ignored entirely. State and partial data are untouched.
- Bytes 0xF0–0xF7 (system common/SysEx): clear running status and go to IDLE. Data bytes in IDLE are discarded.
- WAIT_D1 + data byte: latch d1. For 0xC/0xD status (one data byte), the message completes and the state stays WAIT_D1. Otherwise go to WAIT_D2.
- WAIT_D2 + data byte: the message completes and the state returns to WAIT_D1 (running status).
- Completed messages only act if `channel < NUM_CH`:
  - Note On (0x9), velocity ≠ 0: set `playing[ch]=1`, `cur_note[ch]=d1`, and write `{1,d1}`. This replaces any sounding note (monophonic).
  - Note Off (0x8), or Note On with velocity 0: if `playing[ch]` and `d1==cur_note[ch]`, clear `playing[ch]` and write `{0,cur_note[ch]}`. Otherwise no write.
  - Control Change (0xB) with d1 = 123 (All Notes Off): if `playing[ch]`, clear it and write `{0,cur_note[ch]}`. Otherwise no write.
  - All other messages are parsed for framing only; no write.
- Reset: IDLE, `playing` all 0, `cur_note` all 0, `new_req=0`, `write=0`, `reg_addr=0`, `write_value=0`.

## Timing

- Write latency: `new_req` and `write` are high for exactly one cycle, the cycle after the `rx_valid` of the completing data byte.
- `reg_addr` and `write_value` are registered, valid with `new_req`, and hold their value afterwards.
- There is no backpressure; the responder accepts every request.
- Back-to-back `rx_valid` on consecutive cycles is legal. Each completing byte yields its own request one cycle later, so consecutive-cycle requests are possible.
- `playing`/`cur_note` update in the same edge that registers the request. A message in the very next cycle sees the updated record.
- `rst` mid-message: the partial message is dropped, no request is issued, and the pending `new_req` is cleared on that edge.

## Structure

- Package `midi_pkg`:
  - status nibble constants: NOTE_OFF=0x8, NOTE_ON=0x9, CTRL=0xB, PROG=0xC, CHPRESS=0xD
  - CC_ALL_NOTES_OFF=123
  - parser state enum
  - `data_bytes_for(status)` function
- Sub-module `midi_parser`: byte stream in; `msg_valid`/status/channel/d1/d2 out (one-cycle strobe). The top level holds the channel record and the request register.

## Test plan

- Reset, then bytes 0x92 0x3C 0x40 → one `new_req` one cycle after the last byte, `reg_addr=2`, `write_value=0xBC`, `write=1`.
- Running status: 0x90 0x40 0x7F 0x42 0x7F → two requests, addr 0, values 0xC0 then 0xC2.
- 0x91 0x3C 0x40, then 0x81 0x3D 0x00 → no second request. Then 0x91 0x3C 0x00 → request addr 1, value 0x3C.
- 0x93 0x3C 0xF8 0x40 (real-time byte interleaved) → single request addr 3, value 0xBC. Also 0x93 0x3C 0xF0 0x40 → no request.
- NUM_CH=8: 0x9A 0x3C 0x40 → no request. 0xB4 0x7B 0x00 after a note on channel 4 → request addr 4, value `{0,note}`.
- `rst` asserted between 0x95 0x3C and 0x40 → no request. A following lone 0x40 is discarded (IDLE).
